// File: rtl/mult_div_sequencer_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer.
//   - operation encodings carried on the op port
//   - ALU control codes (must match the shared EX-stage ALU)
//   - FSM state encoding
//   - small decode helpers for the op field
package mult_div_sequencer_pkg;

  localparam int MD_DATA_WIDTH = 32;
  localparam int MD_CTRL_WIDTH = 4;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_NEG_A  = 3'd1,
    ST_NEG_B  = 3'd2,
    ST_ITER   = 3'd3,
    ST_FIX_LO = 3'd4,
    ST_FIX_HI = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  function automatic logic op_is_div(input logic [1:0] op_in);
    return (op_in == OP_DIV) || (op_in == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op_in);
    return (op_in == OP_MULT) || (op_in == OP_DIV);
  endfunction

endpackage

// File: rtl/mult_div_sequencer_step.sv
// mult_div_step: one shift-add / restoring-divide iteration.
// Selects the ALU operands for the current iteration and turns the ALU
// result back into the next accumulator pair.
//   is_div     in  : 1 = divide iteration, 0 = multiply iteration
//   hi_acc     in  : product high half / partial remainder
//   lo_acc     in  : multiplier being shifted out / dividend-quotient
//   mcand      in  : multiplicand / divisor magnitude
//   alu_result in  : combinational ALU result for alu_a +/- alu_b
//   alu_a/b    out : ALU operands for this iteration
//   hi_nxt     out : next hi_acc (remainder)
//   lo_nxt     out : next lo_acc (quotient)
module mult_div_step
  import mult_div_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = MD_DATA_WIDTH
) (
  input  logic                  is_div,
  input  logic [DATA_WIDTH-1:0] hi_acc,
  input  logic [DATA_WIDTH-1:0] lo_acc,
  input  logic [DATA_WIDTH-1:0] mcand,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [DATA_WIDTH-1:0] hi_nxt,
  output logic [DATA_WIDTH-1:0] lo_nxt
);

  localparam int MSB = DATA_WIDTH - 1;

  logic [DATA_WIDTH-1:0] sh;
  logic                  shift_out;
  logic                  carry;
  logic                  borrow;

  // The remainder is conceptually 33 bits wide: shift_out is the bit that
  // falls off the top when the remainder is shifted left.
  assign sh        = {hi_acc[MSB-1:0], lo_acc[MSB]};
  assign shift_out = hi_acc[MSB];

  // Operand selection depends only on registered state, never on alu_result,
  // so the external ALU path stays free of combinational loops.
  assign alu_a = is_div ? sh : hi_acc;
  assign alu_b = is_div ? mcand : (lo_acc[0] ? mcand : '0);

  // Carry-out of alu_a + alu_b and unsigned borrow of alu_a - alu_b,
  // reconstructed from the operand MSBs and the 32-bit result MSB.
  assign carry  = (alu_a[MSB] & alu_b[MSB]) |
                  ((alu_a[MSB] ^ alu_b[MSB]) & ~alu_result[MSB]);
  assign borrow = (~alu_a[MSB] & alu_b[MSB]) |
                  (~(alu_a[MSB] ^ alu_b[MSB]) & alu_result[MSB]);

  always_comb begin
    hi_nxt = hi_acc;
    lo_nxt = lo_acc;
    if (is_div) begin
      if (shift_out | ~borrow) begin
        hi_nxt = alu_result;
        lo_nxt = {lo_acc[MSB-1:0], 1'b1};
      end else begin
        hi_nxt = sh;
        lo_nxt = {lo_acc[MSB-1:0], 1'b0};
      end
    end else begin
      hi_nxt = {carry, alu_result[MSB:1]};
      lo_nxt = {alu_result[0], lo_acc[MSB:1]};
    end
  end

endmodule

// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer: multi-cycle MULT/MULTU/DIV/DIVU unit that borrows the
// shared EX-stage ALU for one iteration per cycle.
//   clock, reset_n          : rising-edge clock, async active-low reset
//   start, op, operand_a/b  : request, accepted only when busy is low
//   busy, done              : busy in every state but IDLE/DONE; done pulses
//   hi_result, lo_result    : product[63:32]/remainder, product[31:0]/quotient
//   alu_request             : tells the datapath mux to route the ALU here
//   alu_control/operand_a/b : ALU drive, ADD with zero operands when idle
//   alu_result              : combinational ALU result, same cycle
// Signed ops run on magnitudes (NEG_A/NEG_B), then fix signs (FIX_LO/FIX_HI).
module mult_div_sequencer
  import mult_div_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = MD_DATA_WIDTH,
  parameter int CTRL_WIDTH = MD_CTRL_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi_result,
  output logic [DATA_WIDTH-1:0] lo_result,
  output logic                  alu_request,
  output logic [CTRL_WIDTH-1:0] alu_control,
  output logic [DATA_WIDTH-1:0] alu_operand_a,
  output logic [DATA_WIDTH-1:0] alu_operand_b,
  input  logic [DATA_WIDTH-1:0] alu_result
);

  localparam int MSB   = DATA_WIDTH - 1;
  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CTRL_WIDTH-1:0] CTL_ADD = CTRL_WIDTH'(ALU_ADD);
  localparam logic [CTRL_WIDTH-1:0] CTL_SUB = CTRL_WIDTH'(ALU_SUB);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  is_div_q, is_div_d;
  logic                  is_signed_q, is_signed_d;
  logic                  sgn_xor_q, sgn_xor_d;      // product / quotient negative
  logic                  rem_neg_q, rem_neg_d;
  logic                  lo_pre_nz_q, lo_pre_nz_d;  // lo_acc != 0 before FIX_LO
  logic [DATA_WIDTH-1:0] hi_acc_q, hi_acc_d;
  logic [DATA_WIDTH-1:0] lo_acc_q, lo_acc_d;
  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;          // multiplicand or divisor
  logic [DATA_WIDTH-1:0] hi_res_q, hi_res_d;
  logic [DATA_WIDTH-1:0] lo_res_q, lo_res_d;

  logic                  busy_c;
  logic [CTRL_WIDTH-1:0] alu_ctl_c;
  logic [DATA_WIDTH-1:0] alu_a_c, alu_b_c;
  logic [DATA_WIDTH-1:0] step_alu_a, step_alu_b, step_hi, step_lo;
  logic [DATA_WIDTH-1:0] hi_fix;

  mult_div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .is_div     (is_div_q),
    .hi_acc     (hi_acc_q),
    .lo_acc     (lo_acc_q),
    .mcand      (mcand_q),
    .alu_result (alu_result),
    .alu_a      (step_alu_a),
    .alu_b      (step_alu_b),
    .hi_nxt     (step_hi),
    .lo_nxt     (step_lo)
  );

  assign busy_c = (state_q != ST_IDLE) && (state_q != ST_DONE);

  // ALU drive depends only on registered state. Negations are 0 - x; in
  // NEG_A/NEG_B the operand being negated is the dividend/divisor for a
  // divide and the multiplicand/multiplier for a multiply.
  always_comb begin
    alu_ctl_c = CTL_ADD;
    alu_a_c   = '0;
    alu_b_c   = '0;
    case (state_q)
      ST_NEG_A: begin
        alu_ctl_c = CTL_SUB;
        alu_b_c   = is_div_q ? lo_acc_q : mcand_q;
      end
      ST_NEG_B: begin
        alu_ctl_c = CTL_SUB;
        alu_b_c   = is_div_q ? mcand_q : lo_acc_q;
      end
      ST_ITER: begin
        alu_ctl_c = is_div_q ? CTL_SUB : CTL_ADD;
        alu_a_c   = step_alu_a;
        alu_b_c   = step_alu_b;
      end
      ST_FIX_LO: begin
        alu_ctl_c = CTL_SUB;
        alu_b_c   = lo_acc_q;
      end
      ST_FIX_HI: begin
        alu_ctl_c = CTL_SUB;
        alu_b_c   = hi_acc_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_div_d    = is_div_q;
    is_signed_d = is_signed_q;
    sgn_xor_d   = sgn_xor_q;
    rem_neg_d   = rem_neg_q;
    lo_pre_nz_d = lo_pre_nz_q;
    hi_acc_d    = hi_acc_q;
    lo_acc_d    = lo_acc_q;
    mcand_d     = mcand_q;
    hi_res_d    = hi_res_q;
    lo_res_d    = lo_res_q;
    hi_fix      = hi_acc_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          is_div_d    = op_is_div(op);
          is_signed_d = op_is_signed(op);
          sgn_xor_d   = operand_a[MSB] ^ operand_b[MSB];
          rem_neg_d   = operand_a[MSB];
          lo_pre_nz_d = 1'b0;
          cnt_d       = CNT_LAST;
          hi_acc_d    = '0;
          // lo_acc holds what gets shifted out: dividend or multiplier.
          lo_acc_d    = op_is_div(op) ? operand_a : operand_b;
          mcand_d     = op_is_div(op) ? operand_b : operand_a;
          if (op_is_div(op) && (operand_b == '0)) begin
            state_d  = ST_DONE;
            hi_res_d = operand_a;
            lo_res_d = '1;
          end else if (op_is_signed(op)) begin
            state_d = ST_NEG_A;
          end else begin
            state_d = ST_ITER;
          end
        end
      end
      ST_NEG_A: begin
        if (alu_b_c[MSB]) begin
          if (is_div_q) lo_acc_d = alu_result;
          else          mcand_d  = alu_result;
        end
        state_d = ST_NEG_B;
      end
      ST_NEG_B: begin
        if (alu_b_c[MSB]) begin
          if (is_div_q) mcand_d  = alu_result;
          else          lo_acc_d = alu_result;
        end
        state_d = ST_ITER;
      end
      ST_ITER: begin
        hi_acc_d = step_hi;
        lo_acc_d = step_lo;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          if (is_signed_q) begin
            state_d = ST_FIX_LO;
          end else begin
            state_d  = ST_DONE;
            hi_res_d = step_hi;
            lo_res_d = step_lo;
          end
        end
      end
      ST_FIX_LO: begin
        lo_pre_nz_d = |lo_acc_q;
        if (sgn_xor_q) lo_acc_d = alu_result;
        state_d = ST_FIX_HI;
      end
      ST_FIX_HI: begin
        // 64-bit negate: the high half takes a borrow unless the low half was 0.
        if (!is_div_q && sgn_xor_q) hi_fix = alu_result - DATA_WIDTH'(lo_pre_nz_q);
        if (is_div_q && rem_neg_q)  hi_fix = alu_result;
        hi_acc_d = hi_fix;
        hi_res_d = hi_fix;
        lo_res_d = lo_acc_q;
        state_d  = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
      is_signed_q <= 1'b0;
      sgn_xor_q   <= 1'b0;
      rem_neg_q   <= 1'b0;
      lo_pre_nz_q <= 1'b0;
      hi_acc_q    <= '0;
      lo_acc_q    <= '0;
      mcand_q     <= '0;
      hi_res_q    <= '0;
      lo_res_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_div_q    <= is_div_d;
      is_signed_q <= is_signed_d;
      sgn_xor_q   <= sgn_xor_d;
      rem_neg_q   <= rem_neg_d;
      lo_pre_nz_q <= lo_pre_nz_d;
      hi_acc_q    <= hi_acc_d;
      lo_acc_q    <= lo_acc_d;
      mcand_q     <= mcand_d;
      hi_res_q    <= hi_res_d;
      lo_res_q    <= lo_res_d;
    end
  end

  assign busy          = busy_c;
  assign done          = (state_q == ST_DONE);
  assign alu_request   = busy_c;
  assign alu_control   = alu_ctl_c;
  assign alu_operand_a = alu_a_c;
  assign alu_operand_b = alu_b_c;
  assign hi_result     = hi_res_q;
  assign lo_result     = lo_res_q;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Testbench for mult_div_sequencer: models the shared ALU, drives a table of
// operations and a few hand-written corner sequences, and checks results and
// latency through a scoreboard queue.
module tb_mult_div_sequencer;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a, operand_b;
  logic        busy, done;
  logic [31:0] hi_result, lo_result;
  logic        alu_request;
  logic [3:0]  alu_control;
  logic [31:0] alu_operand_a, alu_operand_b;
  logic [31:0] alu_result;

  mult_div_sequencer dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .op            (op),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .busy          (busy),
    .done          (done),
    .hi_result     (hi_result),
    .lo_result     (lo_result),
    .alu_request   (alu_request),
    .alu_control   (alu_control),
    .alu_operand_a (alu_operand_a),
    .alu_operand_b (alu_operand_b),
    .alu_result    (alu_result)
  );

  // Shared ALU model: ADD 0010, SUB 0110.
  assign alu_result = (alu_control == 4'b0010) ? alu_operand_a + alu_operand_b :
                      (alu_control == 4'b0110) ? alu_operand_a - alu_operand_b : 32'h0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
    int          lat;
    int          acc;
  } exp_t;

  vec_t vecs[13];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge with busy low; leaves at the negedge after the accept
  // edge. acc records cyc there, so done seen k edges later gives latency k+1
  // counted up to the edge that samples done.
  task automatic drive_start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] hi, input logic [31:0] lo, input int lat);
    exp_t e;
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    op = 2'($urandom); operand_a = $urandom; operand_b = $urandom;
    e.hi = hi; e.lo = lo; e.lat = lat; e.acc = cyc;
    sb.push_back(e);
  endtask

  // Waits (bounded) for done, pops the scoreboard and compares. Returns at
  // the negedge where done is high, so a new start can be driven right away.
  task automatic collect(input string name);
    exp_t e;
    logic seen;
    int   seen_cyc;
    seen = 1'b0;
    seen_cyc = 0;
    for (int k = 0; k < 100; k++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        seen_cyc = cyc;
        break;
      end
      if (k == 0) chk({name, "_busy"}, {31'b0, busy & alu_request}, 32'd1);
      @(negedge clock);
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_timeout: done not seen within 100 cycles", name);
    end
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_sb: scoreboard empty when result arrived", name);
    end else begin
      e = sb.pop_front();
      if (seen) begin
        chk({name, "_hi"}, hi_result, e.hi);
        chk({name, "_lo"}, lo_result, e.lo);
        chk({name, "_lat"}, 32'(seen_cyc - e.acc + 1), 32'(e.lat));
      end
    end
  endtask

  initial begin
    logic extra;
    vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33};
    vecs[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 37};
    vecs[2]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 37};
    vecs[3]  = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        33};
    vecs[4]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 37};
    vecs[5]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 37};
    vecs[6]  = '{2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1};
    vecs[7]  = '{2'b01, 32'h1234_5678, 32'd9,         32'h0000_0000, 32'hA3D7_0A38, 33};
    vecs[8]  = '{2'b00, 32'h8000_0000, 32'd2,         32'hFFFF_FFFF, 32'h0000_0000, 37};
    vecs[9]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 37};
    vecs[10] = '{2'b10, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1};
    vecs[11] = '{2'b11, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 33};
    vecs[12] = '{2'b11, 32'h8000_0001, 32'h8000_0000, 32'd1,         32'd1,         33};

    reset_n = 1'b0; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
    repeat (3) @(negedge clock);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_hi", hi_result, 32'd0);
    chk("rst_lo", lo_result, 32'd0);
    chk("rst_alu_req", {31'b0, alu_request}, 32'd0);
    chk("rst_alu_ctl", {28'b0, alu_control}, 32'h2);
    chk("rst_alu_a", alu_operand_a, 32'd0);
    chk("rst_alu_b", alu_operand_b, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Table; every third op starts from IDLE, the rest back-to-back from DONE.
    for (int i = 0; i < 13; i++) begin
      if (i % 3 == 0) @(negedge clock);
      drive_start(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].lat);
      if (vecs[i].lat == 1) chk($sformatf("vec%0d_nobusy", i), {31'b0, busy}, 32'd0);
      collect($sformatf("vec%0d", i));
    end

    // start pulsed mid-operation is ignored and not queued.
    @(negedge clock);
    drive_start(2'b01, 32'h1234_5678, 32'd9, 32'h0, 32'hA3D7_0A38, 33);
    repeat (9) @(negedge clock);
    op = 2'b11; operand_a = 32'd1; operand_b = 32'd0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    collect("ignored_start");
    extra = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (done || busy) extra = 1'b1;
    end
    chk("ignored_no_queue", {31'b0, extra}, 32'd0);

    // start on the DONE cycle is accepted.
    drive_start(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 33);
    collect("b2b_first");
    drive_start(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    collect("b2b_second");

    // Reset in the middle of ITER drops the op.
    @(negedge clock);
    drive_start(2'b01, 32'h0000_F00D, 32'h0000_BEEF, 32'h0, 32'h0, 33);
    repeat (12) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("midrst_hi", hi_result, 32'd0);
    chk("midrst_lo", lo_result, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    sb.delete();
    extra = 1'b0;
    repeat (2) begin
      @(negedge clock);
      if (done) extra = 1'b1;
    end
    reset_n = 1'b1;
    repeat (30) begin
      @(negedge clock);
      if (done) extra = 1'b1;
    end
    chk("midrst_no_done", {31'b0, extra}, 32'd0);
    drive_start(vecs[1].op, vecs[1].a, vecs[1].b, vecs[1].hi, vecs[1].lo, vecs[1].lat);
    collect("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
